// File: rtl/alu_seq_muldiv.sv
// Handshaked ALU with base integer ops and, with ALU_MULDIV_EN defined,
// an iterative RV-M multiply/divide datapath (one bit per cycle).
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALUcontrol_In,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            busy
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_REM   = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    S_BUSY = 2'd2,
`endif
    S_DONE = 2'd1
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            out_valid_q;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    base_d;

  assign in_ready  = (state_q == S_IDLE)
                   | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign shamt     = B[SHAMT_W-1:0];
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;

  always_comb begin
    base_d = '0;
    case (ALUcontrol_In)
      OP_ADD:  base_d = A + B;
      OP_SUB:  base_d = A - B;
      OP_AND:  base_d = A & B;
      OP_OR:   base_d = A | B;
      OP_XOR:  base_d = A ^ B;
      OP_SLL:  base_d = A << shamt;
      OP_SRL:  base_d = A >> shamt;
      OP_SRA:  base_d = $signed(A) >>> shamt;
      OP_SLT:  base_d = {{(XLEN-1){1'b0}},
                         $signed(A) < $signed(B)};
      OP_SLTU: base_d = {{(XLEN-1){1'b0}}, A < B};
      default: base_d = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [4:0]         op_q;
  logic               neg_q;
  logic               bz_q;
  logic [XLEN-1:0]    opd_q;
  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic            is_m, is_div_d, sgn, sa, sb, neg_d;
  logic [XLEN-1:0] ma, mb;
  logic            is_div_q, dge;
  logic [XLEN:0]   msum, dt;
  logic [XLEN-1:0] ddiff, hi_n, lo_n, mulh_neg, fin_d;

  assign is_m     = (ALUcontrol_In >= OP_MUL)
                  & (ALUcontrol_In <= OP_REMU);
  assign is_div_d = ALUcontrol_In >= OP_DIV;
  assign sgn      = (ALUcontrol_In == OP_MULH)
                  | (ALUcontrol_In == OP_DIV)
                  | (ALUcontrol_In == OP_REM);
  assign sa       = sgn & A[XLEN-1];
  assign sb       = sgn & B[XLEN-1];
  assign ma       = sa ? -A : A;
  assign mb       = sb ? -B : B;
  assign neg_d    = (ALUcontrol_In == OP_REM) ? sa : (sa ^ sb);
  assign is_div_q = op_q >= OP_DIV;

  // hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    dt    = {hi_q, lo_q[XLEN-1]};
    dge   = dt >= {1'b0, opd_q};
    ddiff = dt[XLEN-1:0] - opd_q;
    if (is_div_q) begin
      hi_n = dge ? ddiff : dt[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], dge};
    end else begin
      hi_n = msum[XLEN:1];
      lo_n = {msum[0], lo_q[XLEN-1:1]};
    end
  end

  // High half of the negated 2*XLEN product
  assign mulh_neg = ~hi_n
                  + {{(XLEN-1){1'b0}}, lo_n == '0};

  always_comb begin
    fin_d = '0;
    case (op_q)
      OP_MUL:   fin_d = lo_n;
      OP_MULH:  fin_d = neg_q ? mulh_neg : hi_n;
      OP_MULHU: fin_d = hi_n;
      OP_DIV,
      OP_DIVU:  fin_d = bz_q ? '1
                      : (neg_q ? -lo_n : lo_n);
      default:  fin_d = neg_q ? -hi_n : hi_n;
    endcase
  end

  assign busy = state_q == S_BUSY;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      op_q        <= '0;
      neg_q       <= 1'b0;
      bz_q        <= 1'b0;
      opd_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= fin_d;
            zero_q      <= fin_d == '0;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (is_m) begin
              state_q     <= S_BUSY;
              out_valid_q <= 1'b0;
              op_q        <= ALUcontrol_In;
              neg_q       <= neg_d;
              bz_q        <= B == '0;
              cnt_q       <= SHAMT_W'(XLEN-1);
              hi_q        <= '0;
              opd_q       <= is_div_d ? mb : ma;
              lo_q        <= is_div_d ? ma : mb;
            end else
`endif
            begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= base_d;
              zero_q      <= base_d == '0;
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv; reference model follows
// ALU_MULDIV_EN the same way the design does.
module tb_alu_seq_muldiv;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Result;
  logic        Zero;
  logic        busy;

  alu_seq_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUcontrol_In(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    bit          m;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int or_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_mop(input logic [4:0] o);
`ifdef ALU_MULDIV_EN
    return (o >= 5'd10) && (o <= 5'd16);
`else
    return (o != o);
`endif
  endfunction

  function automatic logic [31:0] model(input logic [4:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    longint sa, sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = '0;
    case (o)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return a << b[4:0];
      5'd6: return a >> b[4:0];
      5'd7: return 32'($signed(a) >>> b[4:0]);
      5'd8: return {31'b0, $signed(a) < $signed(b)};
      5'd9: return {31'b0, a < b};
`ifdef ALU_MULDIV_EN
      5'd10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      5'd11: begin p = 64'(sa * sbv); return p[63:32]; end
      5'd12: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      5'd13: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sbv);
      end
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd15: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32'(sa % sbv);
      end
      5'd16: return (b == 0) ? a : a % b;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    int   waitc;
    bit   ok;
    waitc = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    while (!ok && waitc < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waitc++;
    end
    if (!ok) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'h1);
      in_valid = 1'b0;
    end else begin
      e.res = model(o, a, b);
      e.m   = is_mop(o);
      e.lat = e.m ? XLEN + 1 : 1;
      e.acc = cyc;
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  exp_t        me;
  bit          mnew = 1'b1;
  int          first_cyc = 0;
  logic [31:0] held = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mnew = 1'b1;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'h0);
        end else begin
          if (mnew) begin
            mnew = 1'b0;
            first_cyc = cyc;
            held = Result;
          end else begin
            chk("hold_result", Result, held);
          end
          chk("busy_with_valid", {31'b0, busy}, 32'h0);
          if (!out_ready) begin
            chk("in_ready_stall", {31'b0, in_ready}, 32'h0);
          end else begin
            me = sb.pop_front();
            chk("result", Result, me.res);
            chk("zero", {31'b0, Zero}, {31'b0, me.res == 0});
            chk("latency", 32'(first_cyc - me.acc), 32'(me.lat));
            mnew = 1'b1;
          end
        end
      end else begin
        chk("busy", {31'b0, busy},
            {31'b0, (sb.size() != 0) && sb[0].m});
      end
    end
  end

  task automatic reset_values();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", Result, 32'h0);
    chk("rst_zero", {31'b0, Zero}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [4:0] ro;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    reset_values();
    @(posedge clk);
    #1;

    issue(5'd0, 32'd5, 32'd3);
    issue(5'd1, 32'd0, 32'd0);
    issue(5'd7, 32'h8000_0000, 32'd4);
    issue(5'd6, 32'h8000_0000, 32'd4);
    issue(5'd8, 32'hFFFF_FFFF, 32'd1);
    issue(5'd9, 32'hFFFF_FFFF, 32'd1);
    issue(5'd10, 32'd7, 32'hFFFF_FFFD);
    issue(5'd11, 32'h8000_0000, 32'h8000_0000);
    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(5'd13, 32'h14, 32'h0);
    issue(5'd15, 32'h14, 32'h0);
    issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'd14, 32'h64, 32'd7);
    issue(5'd16, 32'h64, 32'd7);
    issue(5'd13, 32'hFFFF_FFF9, 32'd2);
    issue(5'd15, 32'hFFFF_FFF9, 32'd2);
    issue(5'd31, 32'd9, 32'd9);
    issue(5'd17, 32'd1, 32'd2);
    issue(5'd10, 32'd7, 32'd3);

    // Consumer stalls, then drains while a new op waits
    or_mode = 1;
    @(posedge clk);
    #2;
    issue(5'd0, 32'h1234, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    fork
      issue(5'd0, 32'd9, 32'd1);
      begin
        repeat (3) @(posedge clk);
        or_mode = 0;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an op that is never consumed
    or_mode = 1;
    @(posedge clk);
    #2;
    issue(5'd13, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    reset_values();
    or_mode = 0;
    repeat (XLEN + 5) @(negedge clk);
    @(posedge clk);
    #1;

    or_mode = 2;
    for (int i = 0; i < 250; i++) begin
      ro = 5'($urandom_range(0, 20));
      if (ro > 5'd16) ro = 5'($urandom_range(17, 31));
      issue(ro, rnd_opnd(), rnd_opnd());
    end

    or_mode = 0;
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'h0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle RISC-V ALU.
- Executes the base integer ops (ADD..SLT) plus SLTU.
- Executes the RV-M multiply/divide ops on an iterative datapath of width XLEN.
- Sits between the decode/operand stage and writeback. The core's hazard logic stalls on in_ready/out_valid instead of assuming fixed latency.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, ≥8.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from B; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept this cycle
- A  in  XLEN  operand A
- B  in  XLEN  operand B
- ALUcontrol_In  in  5  operation code
- out_valid  out  1  Result/Zero valid
- out_ready  in  1  consumer accepts result
- Result  out  XLEN  registered result
- Zero  out  1  registered, 1 when Result==0
- busy  out  1  iterative op in progress

Behaviour:
- Op codes:
  - 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR
  - 05 SLL, 06 SRL, 07 SRA (shift by B[SHAMT_W-1:0])
  - 08 SLT (signed), 09 SLTU (unsigned)
  - 10 MUL (low), 11 MULH (s×s high), 12 MULHU (u×u high)
  - 13 DIV, 14 DIVU, 15 REM, 16 REMU
  - Any other code: Result=0, Zero=1, latency 1.
- Reset (rst_n low at a clk edge):
  - State IDLE; out_valid=0, Result=0, Zero=1, busy=0.
  - Iteration counter and partial registers cleared.
  - Takes effect from any state; an in-flight op is discarded with no output.
- Accept: in_valid & in_ready at a clk edge latches A, B and the op.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back issue.
- FSM transitions:
  - IDLE → DONE on accept of a base op. Result is computed combinationally and registered, so out_valid rises the cycle after accept (latency 1).
  - IDLE → BUSY on accept of an M op.
  - BUSY runs exactly XLEN iterations (counter XLEN-1 down to 0), then goes to DONE. out_valid rises XLEN+1 cycles after accept.
  - DONE holds Result/Zero/out_valid stable while out_ready=0.
  - DONE with out_ready=1: to IDLE, or directly to DONE/BUSY if a new op is accepted the same cycle.
- busy=1 only in BUSY. in_valid is ignored in BUSY.
- Multiply: shift-add on magnitudes, then sign-corrected. Operand signedness per op: MUL any, MULH s/s, MULHU u/u. Product is 2·XLEN bits; low or high half selected.
- Divide: restoring, on magnitudes for signed ops. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Divide corner cases (still take the full XLEN+1 latency):
  - B=0: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (A=most-negative, B=-1): DIV gives A; REM gives 0.
- Zero is computed from the final Result value in every case.
- Simultaneous events:
  - Result consumed and new op accepted in the same cycle: the new op starts, with no bubble for base ops.
  - rst_n low overrides everything.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: codes 10–16 execute as above; BUSY state and iterative datapath exist.
- Undefined: no BUSY state or datapath; busy tied 0. Codes 10–16 behave as unsupported codes (Result=0, Zero=1, latency 1).

Test Plan:
- Reset, then ADD A=5, B=3 → out_valid one cycle after accept; Result=00000008, Zero=0. Then SUB A=0, B=0 → Result=0, Zero=1.
- SRA A=80000000, B=4 → F8000000. SRL same → 08000000. SLT A=FFFFFFFF, B=1 → 1. SLTU same → 0.
- MUL A=7, B=FFFFFFFD → FFFFFFEB exactly 33 cycles after accept; busy high 32 cycles. MULH A=B=80000000 → 40000000.
- DIV A=0x14, B=0 → FFFFFFFF. REM same → 14. DIV A=80000000, B=FFFFFFFF → 80000000. REM same → 0. DIVU A=0x64, B=7 → 0E. REMU same → 2.
- Hold out_ready=0 for 5 cycles after a result → Result/out_valid stable, in_ready=0. Raise out_ready with a new ADD pending → consumed and accepted the same edge; next result valid one cycle later.
- Drive rst_n low mid-DIV (cycle 10 of BUSY) → next cycle IDLE, out_valid=0, Result=0, Zero=1, busy=0, and no stale result ever appears. Rebuild without ALU_MULDIV_EN; MUL A=7, B=3 → Result=0, Zero=1, latency 1.
